// File: rtl/arm_multicycle_ctrl.sv
// arm_multicycle_ctrl
// Control unit for a multicycle ARM datapath. A main FSM steps each
// instruction through fetch, decode, memory, ALU and branch phases, and
// drives the datapath enables and mux selects for every phase. The N/Z/C/V
// flags and the conditional-execution decision are held here as well.
//
// Ports
//   clk         system clock, rising edge
//   reset       synchronous, active-high
//   Instr       instruction register contents
//   ALUFlags    {N,Z,C,V} from the combinational ALU
//   PCWrite, RegWrite, MemWrite, IRWrite   write enables
//   AdrSrc      memory address select (0=PC, 1=Result)
//   RegSrc      [0] RA1=R15, [1] RA2=Rd
//   ALUSrcA/B, ResultSrc, ImmSrc, ALUControl   datapath selects
//   state       current FSM state (debug)
//
// Build option
//   CTRL_CMP_EN  when defined, cmd=1010 (CMP) decodes as SUB and suppresses
//                the register writeback; otherwise it decodes as ADD.
//
// state  | meaning
// FETCH  | read instruction at PC, PC <= PC+4
// DECODE | read registers, latch condition result
// MEMADR | compute load/store address
// MEMRD  | read data memory
// MEMWB  | write loaded data to Rd
// MEMWR  | write data memory
// EXECR  | ALU op with register operand
// EXECI  | ALU op with immediate operand
// ALUWB  | write ALU result to Rd
// BRANCH | PC <= PC+8+offset
module arm_multicycle_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Instr,
  input  logic [3:0]  ALUFlags,
  output logic        PCWrite,
  output logic        RegWrite,
  output logic        MemWrite,
  output logic        IRWrite,
  output logic        AdrSrc,
  output logic [1:0]  RegSrc,
  output logic [1:0]  ALUSrcA,
  output logic [1:0]  ALUSrcB,
  output logic [1:0]  ResultSrc,
  output logic [1:0]  ImmSrc,
  output logic [1:0]  ALUControl,
  output logic [3:0]  state
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXECR  = 4'd6,
    S_EXECI  = 4'd7,
    S_ALUWB  = 4'd8,
    S_BRANCH = 4'd9
  } state_t;

  state_t     state_q, state_d;
  logic [3:0] flags_q, flags_d;   // {N,Z,C,V}
  logic       condex_q, condex_d;

  logic [1:0] op;
  logic [5:0] funct;
  logic [3:0] cond;
  logic [3:0] cmd;
  assign op    = Instr[27:26];
  assign funct = Instr[25:20];
  assign cond  = Instr[31:28];
  assign cmd   = funct[4:1];

  // Register numbers and immediate bits are consumed by the datapath only.
  logic unused_instr;
  assign unused_instr = ^Instr[19:0];

  logic flag_n, flag_z, flag_c, flag_v;
  assign {flag_n, flag_z, flag_c, flag_v} = flags_q;

  logic cond_pass;
  always_comb begin
    cond_pass = 1'b0;
    case (cond)
      4'b0000: cond_pass = flag_z;
      4'b0001: cond_pass = ~flag_z;
      4'b0010: cond_pass = flag_c;
      4'b0011: cond_pass = ~flag_c;
      4'b0100: cond_pass = flag_n;
      4'b0101: cond_pass = ~flag_n;
      4'b0110: cond_pass = flag_v;
      4'b0111: cond_pass = ~flag_v;
      4'b1000: cond_pass = flag_c & ~flag_z;
      4'b1001: cond_pass = ~flag_c | flag_z;
      4'b1010: cond_pass = (flag_n == flag_v);
      4'b1011: cond_pass = (flag_n != flag_v);
      4'b1100: cond_pass = ~flag_z & (flag_n == flag_v);
      4'b1101: cond_pass = flag_z | (flag_n != flag_v);
      4'b1110: cond_pass = 1'b1;
      default: cond_pass = 1'b0;
    endcase
  end

  // ALU operation for data-processing instructions; unsupported cmds run as ADD.
  logic [1:0] alu_dec;
  logic       no_write;
  always_comb begin
    alu_dec  = 2'b00;
    no_write = 1'b0;
    case (cmd)
      4'b0100: alu_dec = 2'b00;
      4'b0010: alu_dec = 2'b01;
      4'b0000: alu_dec = 2'b10;
      4'b1100: alu_dec = 2'b11;
`ifdef CTRL_CMP_EN
      4'b1010: begin
        alu_dec  = 2'b01;
        no_write = 1'b1;
      end
`endif
      default: alu_dec = 2'b00;
    endcase
  end

  logic in_exec;
  assign in_exec = (state_q == S_EXECR) || (state_q == S_EXECI);

  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        case (op)
          2'b01:   state_d = S_MEMADR;
          2'b00:   state_d = funct[5] ? S_EXECI : S_EXECR;
          2'b10:   state_d = S_BRANCH;
          default: state_d = S_FETCH;
        endcase
      end
      S_MEMADR: state_d = funct[0] ? S_MEMRD : S_MEMWR;
      S_MEMRD:  state_d = S_MEMWB;
      S_EXECR,
      S_EXECI:  state_d = S_ALUWB;
      default:  state_d = S_FETCH;
    endcase
  end

  // Flags change at the end of EXEC, so the same instruction's ALUWB still
  // sees its own condex_q, which was latched back in DECODE.
  always_comb begin
    flags_d = flags_q;
    if (in_exec && funct[0] && condex_q) begin
      flags_d[3:2] = ALUFlags[3:2];
      if (alu_dec[1] == 1'b0) flags_d[1:0] = ALUFlags[1:0];
    end
  end

  assign condex_d = (state_q == S_DECODE) ? cond_pass : condex_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_FETCH;
      flags_q  <= 4'b0000;
      condex_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      flags_q  <= flags_d;
      condex_q <= condex_d;
    end
  end

  // Per-state datapath controls, decoded from the registered state.
  logic pc_write_c, reg_write_c, mem_write_c, ir_write_c;
  always_comb begin
    pc_write_c  = 1'b0;
    reg_write_c = 1'b0;
    mem_write_c = 1'b0;
    ir_write_c  = 1'b0;
    AdrSrc      = 1'b0;
    ALUSrcA     = 2'b00;
    ALUSrcB     = 2'b00;
    ResultSrc   = 2'b00;
    ALUControl  = 2'b00;
    case (state_q)
      S_FETCH: begin
        ir_write_c = 1'b1;
        pc_write_c = 1'b1;
        ALUSrcA    = 2'b01;
        ALUSrcB    = 2'b10;
        ResultSrc  = 2'b10;
      end
      S_DECODE: begin
        ALUSrcA   = 2'b01;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
      end
      S_MEMADR: ALUSrcB = 2'b01;
      S_MEMRD:  AdrSrc = 1'b1;
      S_MEMWB: begin
        ResultSrc   = 2'b01;
        reg_write_c = condex_q;
      end
      S_MEMWR: begin
        AdrSrc      = 1'b1;
        mem_write_c = condex_q;
      end
      S_EXECR:  ALUControl = alu_dec;
      S_EXECI: begin
        ALUSrcB    = 2'b01;
        ALUControl = alu_dec;
      end
      S_ALUWB:  reg_write_c = condex_q & ~no_write;
      S_BRANCH: begin
        ALUSrcB    = 2'b01;
        ResultSrc  = 2'b10;
        pc_write_c = condex_q;
      end
      default: ;
    endcase
  end

  // Architectural writes are blocked for the whole time reset is held.
  assign PCWrite  = pc_write_c  & ~reset;
  assign RegWrite = reg_write_c & ~reset;
  assign MemWrite = mem_write_c & ~reset;
  assign IRWrite  = ir_write_c  & ~reset;

  assign ImmSrc    = op;
  assign RegSrc[0] = (op == 2'b10);
  assign RegSrc[1] = (op == 2'b01);
  assign state     = state_q;

endmodule
